// File: rtl/ulpi_reg_seq.sv
// ulpi_reg_seq
//   ULPI PHY register sequencer on the 60 MHz PHY clock domain (CLK_60M).
//   It drives the pipelined register-access port of ulpi_wrapper. After reset,
//   or on start_i, it writes the fixed PHY init list:
//     04 <= 45, 07 <= 00, 0A <= 00
//   It then polls POLL_ADDR every 2^POLL_DIV cycles. Every access is protected
//   by an ack timeout.
//
//   Optional feature macro: ULPI_REG_SEQ_VERIFY_EN
//     When defined, a verify read of 04 follows the writes. If the value read,
//     with the Reset bit masked, is not 45, the sequencer goes to ERROR.
//
// Ports
//   clk_i        60 MHz PHY clock
//   rst_i        asynchronous active-high reset
//   start_i      one-cycle pulse, restarts the init sequence from any state
//   reg_addr_o   register address        reg_stb_o   access strobe
//   reg_we_o     1 = write, 0 = read     reg_data_o  write data
//   reg_data_i   read data (with ack)    reg_ack_i   one-cycle acknowledge
//   busy_o       init access in progress
//   done_o       init completed, sticky until restart
//   err_o        timeout or verify mismatch, sticky until restart
//   poll_data_o  last polled value       poll_valid_o one-cycle update pulse
//   led_o        {err, done, busy, state[2:0], step[1:0]}
module ulpi_reg_seq #(
    parameter int         POLL_DIV    = 23,
    parameter int         ACK_TIMEOUT = 255,
    parameter logic [7:0] POLL_ADDR   = 8'h04
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    output logic [7:0] reg_addr_o,
    output logic       reg_stb_o,
    output logic       reg_we_o,
    output logic [7:0] reg_data_o,
    input  logic [7:0] reg_data_i,
    input  logic       reg_ack_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [7:0] poll_data_o,
    output logic       poll_valid_o,
    output logic [7:0] led_o
);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_ISSUE     = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
    localparam logic [2:0] ST_GAP       = 3'd3;
    localparam logic [2:0] ST_POLL_WAIT = 3'd4;
    localparam logic [2:0] ST_ERROR     = 3'd5;

`ifdef ULPI_REG_SEQ_VERIFY_EN
    localparam logic [1:0] LAST_STEP = 2'd3;
`else
    localparam logic [1:0] LAST_STEP = 2'd2;
`endif

    // Drop stb on the edge that closes the ACK_TIMEOUT-th cycle of waiting.
    localparam logic [7:0]          TIMEOUT_LAST = 8'(ACK_TIMEOUT - 1);
    localparam logic [POLL_DIV-1:0] POLL_LAST    = '1;
    localparam logic [POLL_DIV-1:0] POLL_ONE     = POLL_DIV'(1);

    function automatic logic [7:0] step_addr(input logic [1:0] s);
        case (s)
            2'd0:    step_addr = 8'h04;
            2'd1:    step_addr = 8'h07;
            2'd2:    step_addr = 8'h0A;
            default: step_addr = 8'h04;
        endcase
    endfunction

    function automatic logic [7:0] step_data(input logic [1:0] s);
        // Function Control: FS transceiver, TermSelect, SuspendM, normal opmode.
        // All other entries write zero.
        step_data = (s == 2'd0) ? 8'h45 : 8'h00;
    endfunction

    logic [2:0]          state, state_n;
    logic [1:0]          step, step_n;
    logic                poll_phase, poll_phase_n;
    logic [7:0]          wait_cnt, wait_cnt_n;
    logic [POLL_DIV-1:0] poll_cnt, poll_cnt_n;
    logic [7:0]          addr_n, data_n, poll_data_n;
    logic                stb_n, we_n, done_n, err_n, busy_n, poll_valid_n;

`ifdef ULPI_REG_SEQ_VERIFY_EN
    logic [7:0] rd_data;

    // Capture read data on the ack cycle; start_i aborts the access.
    always_ff @(posedge clk_i) begin
        if (state == ST_WAIT_ACK && reg_ack_i && !start_i && !reg_we_o)
            rd_data <= reg_data_i;
    end
`endif

    always_comb begin
        state_n      = state;
        step_n       = step;
        poll_phase_n = poll_phase;
        wait_cnt_n   = wait_cnt;
        poll_cnt_n   = poll_cnt;
        addr_n       = reg_addr_o;
        data_n       = reg_data_o;
        we_n         = reg_we_o;
        stb_n        = reg_stb_o;
        done_n       = done_o;
        err_n        = err_o;
        poll_data_n  = poll_data_o;
        poll_valid_n = 1'b0;

        if (start_i) begin
            // Restart wins over everything, including a same-cycle ack.
            state_n      = ST_IDLE;
            stb_n        = 1'b0;
            step_n       = 2'd0;
            poll_phase_n = 1'b0;
            done_n       = 1'b0;
            err_n        = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    step_n       = 2'd0;
                    poll_phase_n = 1'b0;
                    state_n      = ST_ISSUE;
                end
                ST_ISSUE: begin
                    addr_n     = poll_phase ? POLL_ADDR : step_addr(step);
                    we_n       = !poll_phase && (step != 2'd3);
                    data_n     = poll_phase ? 8'h00 : step_data(step);
                    stb_n      = 1'b1;
                    wait_cnt_n = 8'd0;
                    state_n    = ST_WAIT_ACK;
                end
                ST_WAIT_ACK: begin
                    if (reg_ack_i) begin
                        stb_n   = 1'b0;
                        state_n = ST_GAP;
                        if (poll_phase) begin
                            poll_data_n  = reg_data_i;
                            poll_valid_n = 1'b1;
                        end
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        stb_n   = 1'b0;
                        err_n   = 1'b1;
                        state_n = ST_ERROR;
                    end else begin
                        wait_cnt_n = wait_cnt + 8'd1;
                    end
                end
                ST_GAP: begin
                    if (poll_phase) begin
                        poll_cnt_n = '0;
                        state_n    = ST_POLL_WAIT;
                    end else if (step == LAST_STEP) begin
`ifdef ULPI_REG_SEQ_VERIFY_EN
                        // Mask the self-clearing Reset bit before comparing.
                        if ((rd_data & 8'hDF) != 8'h45) begin
                            err_n   = 1'b1;
                            done_n  = 1'b0;
                            state_n = ST_ERROR;
                        end else begin
                            done_n       = 1'b1;
                            poll_phase_n = 1'b1;
                            poll_cnt_n   = '0;
                            state_n      = ST_POLL_WAIT;
                        end
`else
                        done_n       = 1'b1;
                        poll_phase_n = 1'b1;
                        poll_cnt_n   = '0;
                        state_n      = ST_POLL_WAIT;
`endif
                    end else begin
                        step_n  = step + 2'd1;
                        state_n = ST_ISSUE;
                    end
                end
                ST_POLL_WAIT: begin
                    poll_cnt_n = poll_cnt + POLL_ONE;
                    if (poll_cnt == POLL_LAST)
                        state_n = ST_ISSUE;
                end
                ST_ERROR: begin
                    state_n = ST_ERROR;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end

        busy_n = !poll_phase_n &&
                 (state_n == ST_ISSUE || state_n == ST_WAIT_ACK || state_n == ST_GAP);
    end

    // Registered outputs: every output is the registered image of its next value.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            step         <= 2'd0;
            poll_phase   <= 1'b0;
            wait_cnt     <= 8'd0;
            poll_cnt     <= '0;
            reg_addr_o   <= 8'h00;
            reg_data_o   <= 8'h00;
            reg_we_o     <= 1'b0;
            reg_stb_o    <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            err_o        <= 1'b0;
            poll_data_o  <= 8'h00;
            poll_valid_o <= 1'b0;
            led_o        <= 8'h00;
        end else begin
            state        <= state_n;
            step         <= step_n;
            poll_phase   <= poll_phase_n;
            wait_cnt     <= wait_cnt_n;
            poll_cnt     <= poll_cnt_n;
            reg_addr_o   <= addr_n;
            reg_data_o   <= data_n;
            reg_we_o     <= we_n;
            reg_stb_o    <= stb_n;
            busy_o       <= busy_n;
            done_o       <= done_n;
            err_o        <= err_n;
            poll_data_o  <= poll_data_n;
            poll_valid_o <= poll_valid_n;
            led_o        <= {err_n, done_n, busy_n, state_n, step_n};
        end
    end

endmodule

// File: tb/tb_ulpi_reg_seq.sv
// Directed bench for ulpi_reg_seq (POLL_DIV = 4). Works with or without
// ULPI_REG_SEQ_VERIFY_EN; the expected init list follows the same macro.
module tb_ulpi_reg_seq;

    typedef struct {
        logic [7:0] addr;   // expected address
        logic       we;     // expected direction
        logic [7:0] wdata;  // expected write data
        logic [7:0] rdata;  // read data returned with ack
    } acc_t;

`ifdef ULPI_REG_SEQ_VERIFY_EN
    localparam int         N_INIT   = 4;
    localparam logic [7:0] LED_DONE = 8'h53;
`else
    localparam int         N_INIT   = 3;
    localparam logic [7:0] LED_DONE = 8'h52;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] reg_data_i = 8'h00;
    logic       reg_ack_i = 1'b0;
    logic [7:0] reg_addr_o, reg_data_o, poll_data_o, led_o;
    logic       reg_stb_o, reg_we_o, busy_o, done_o, err_o, poll_valid_o;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    ulpi_reg_seq #(.POLL_DIV(4), .ACK_TIMEOUT(255), .POLL_ADDR(8'h04)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start),
        .reg_addr_o(reg_addr_o), .reg_stb_o(reg_stb_o), .reg_we_o(reg_we_o),
        .reg_data_o(reg_data_o), .reg_data_i(reg_data_i), .reg_ack_i(reg_ack_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .poll_data_o(poll_data_o), .poll_valid_o(poll_valid_o), .led_o(led_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check32(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Wait (bounded) for stb; returns at the negedge of the first stb-high cycle.
    task automatic wait_stb(output int rise, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (reg_stb_o) begin
                seen = 1'b1;
                break;
            end
        end
        rise = cyc;
        check1("stb_seen", reg_stb_o, 1'b1);
    endtask

    // One access, acked n cycles after stb rises; returns at the negedge of
    // the cycle after the ack (GAP), where stb must be low again.
    task automatic do_access(input acc_t v, input int n, input logic exp_busy, output int rise);
        bit seen;
        wait_stb(rise, seen);
        if (seen) begin
            check8("addr", reg_addr_o, v.addr);
            check1("we", reg_we_o, v.we);
            if (v.we) check8("wdata", reg_data_o, v.wdata);
            repeat (n) @(negedge clk);
            check8("addr_held", reg_addr_o, v.addr);
            check1("stb_held", reg_stb_o, 1'b1);
            reg_ack_i  = 1'b1;
            reg_data_i = v.rdata;
            @(negedge clk);
            reg_ack_i  = 1'b0;
            reg_data_i = 8'h00;
            check1("stb_drop", reg_stb_o, 1'b0);
            check1("busy_gap", busy_o, exp_busy);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    acc_t init_tab[4];
    acc_t poll_a, poll_b, bad_verify;
    int   rise[4];
    int   r0, r1, hi;
    bit   seen;

    initial begin
        init_tab[0] = '{addr: 8'h04, we: 1'b1, wdata: 8'h45, rdata: 8'h00};
        init_tab[1] = '{addr: 8'h07, we: 1'b1, wdata: 8'h00, rdata: 8'h00};
        init_tab[2] = '{addr: 8'h0A, we: 1'b1, wdata: 8'h00, rdata: 8'h00};
        init_tab[3] = '{addr: 8'h04, we: 1'b0, wdata: 8'h00, rdata: 8'h45};
        poll_a      = '{addr: 8'h04, we: 1'b0, wdata: 8'h00, rdata: 8'h5A};
        poll_b      = '{addr: 8'h04, we: 1'b0, wdata: 8'h00, rdata: 8'h3C};
        bad_verify  = '{addr: 8'h04, we: 1'b0, wdata: 8'h00, rdata: 8'h41};

        // Reset state
        repeat (3) @(negedge clk);
        check1("rst_stb", reg_stb_o, 1'b0);
        check1("rst_busy", busy_o, 1'b0);
        check1("rst_done", done_o, 1'b0);
        check1("rst_err", err_o, 1'b0);
        check1("rst_pvalid", poll_valid_o, 1'b0);
        check8("rst_addr", reg_addr_o, 8'h00);
        check8("rst_data", reg_data_o, 8'h00);
        check8("rst_pdata", poll_data_o, 8'h00);
        check8("rst_led", led_o, 8'h00);
        rst = 1'b0;

        // Init list in order, ack 2 cycles after stb
        for (int k = 0; k < N_INIT; k++) do_access(init_tab[k], 2, 1'b1, rise[k]);
        check32("cadence", rise[1] - rise[0], 5);
        @(negedge clk);
        check1("init_done", done_o, 1'b1);
        check1("init_err", err_o, 1'b0);
        check1("init_busy", busy_o, 1'b0);
        check8("init_led", led_o, LED_DONE);

        // Ack outside WAIT_ACK is ignored
        reg_ack_i = 1'b1; reg_data_i = 8'hFF;
        @(negedge clk);
        reg_ack_i = 1'b0; reg_data_i = 8'h00;
        @(negedge clk);
        check1("stray_ack_pvalid", poll_valid_o, 1'b0);
        check8("stray_ack_pdata", poll_data_o, 8'h00);

        // Poll reads of 04 every 16 + access cycles
        do_access(poll_a, 2, 1'b0, r0);
        check1("poll_valid", poll_valid_o, 1'b1);
        check8("poll_data", poll_data_o, 8'h5A);
        @(negedge clk);
        check1("poll_valid_pulse", poll_valid_o, 1'b0);
        do_access(poll_b, 2, 1'b0, r1);
        check32("poll_period", r1 - r0, 21);
        check8("poll_data2", poll_data_o, 8'h3C);
        check1("poll_done_kept", done_o, 1'b1);

        // start during poll restarts; then start + ack together in step 1
        pulse_start();
        check1("restart_done_clr", done_o, 1'b0);
        check8("restart_led", led_o, 8'h00);
        do_access(init_tab[0], 2, 1'b1, r0);
        wait_stb(r1, seen);
        check8("abort_addr", reg_addr_o, 8'h07);
        @(negedge clk);
        start = 1'b1; reg_ack_i = 1'b1; reg_data_i = 8'h5A;
        @(negedge clk);
        start = 1'b0; reg_ack_i = 1'b0; reg_data_i = 8'h00;
        check1("abort_stb", reg_stb_o, 1'b0);
        check1("abort_err", err_o, 1'b0);
        check8("abort_led", led_o, 8'h00);
        for (int k = 0; k < N_INIT; k++) do_access(init_tab[k], 2, 1'b1, rise[k]);
        check32("restart_cadence", rise[1] - rise[0], 5);
        @(negedge clk);
        check1("restart_done", done_o, 1'b1);

`ifdef ULPI_REG_SEQ_VERIFY_EN
        // Verify mismatch
        pulse_start();
        for (int k = 0; k < 3; k++) do_access(init_tab[k], 2, 1'b1, rise[k]);
        do_access(bad_verify, 2, 1'b1, r0);
        @(negedge clk);
        check1("verify_err", err_o, 1'b1);
        check1("verify_done", done_o, 1'b0);
        check1("verify_busy", busy_o, 1'b0);
        check8("verify_led", led_o, 8'h97);
        hi = 0;
        repeat (40) begin @(negedge clk); if (reg_stb_o) hi++; end
        check32("verify_no_stb", hi, 0);
`endif

        // Timeout on the second write
        pulse_start();
        do_access(init_tab[0], 2, 1'b1, r0);
        wait_stb(r1, seen);
        check8("to_addr", reg_addr_o, 8'h07);
        hi = seen ? 1 : 0;
        for (int i = 0; i < 400 && seen; i++) begin
            @(negedge clk);
            if (!reg_stb_o) break;
            hi++;
        end
        check32("to_stb_cycles", hi, 255);
        check1("to_err", err_o, 1'b1);
        check1("to_done", done_o, 1'b0);
        check8("to_addr_kept", reg_addr_o, 8'h07);
        check8("to_led", led_o, 8'h95);
        hi = 0;
        repeat (20) begin @(negedge clk); if (reg_stb_o) hi++; end
        check32("to_no_stb", hi, 0);

        // Asynchronous reset mid-access
        pulse_start();
        wait_stb(r0, seen);
        #2 rst = 1'b1;
        #1;
        check1("arst_stb", reg_stb_o, 1'b0);
        check1("arst_err", err_o, 1'b0);
        check8("arst_led", led_o, 8'h00);
        check8("arst_addr", reg_addr_o, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        do_access(init_tab[0], 2, 1'b1, r0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
